// File: rtl/fir_pkg.sv
// Shared definitions for the FIR filter control path.
// Op encodings, register-file map and sequencer state encoding.
package fir_pkg;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_COPY  = 3'd1,
    OP_LOAD1 = 3'd2,
    OP_LOAD2 = 3'd3,
    OP_ADD   = 3'd4,
    OP_SUB   = 3'd5,
    OP_MUL   = 3'd6
  } op_t;

  localparam logic [3:0] REG_ACC   = 4'd0;
  localparam logic [3:0] REG_S1    = 4'd1;
  localparam logic [3:0] REG_S2    = 4'd2;
  localparam logic [3:0] REG_S3    = 4'd3;
  localparam logic [3:0] REG_S4    = 4'd4;
  localparam logic [3:0] REG_STAGE = 4'd5;
  localparam logic [3:0] REG_F0    = 4'd6;
  localparam logic [3:0] REG_F1    = 4'd7;
  localparam logic [3:0] REG_F2    = 4'd8;
  localparam logic [3:0] REG_F3    = 4'd9;
  localparam logic [3:0] REG_TMP   = 4'd10;

  typedef enum logic [4:0] {
    ST_IDLE   = 5'd0,
    ST_STORE  = 5'd1,
    ST_SHIFT4 = 5'd2,
    ST_SHIFT3 = 5'd3,
    ST_SHIFT2 = 5'd4,
    ST_SHIFT1 = 5'd5,
    ST_ZERO   = 5'd6,
    ST_MUL1   = 5'd7,
    ST_ADD1   = 5'd8,
    ST_MUL2   = 5'd9,
    ST_SUB2   = 5'd10,
    ST_MUL3   = 5'd11,
    ST_ADD3   = 5'd12,
    ST_MUL4   = 5'd13,
    ST_SUB4   = 5'd14,
    ST_DONE   = 5'd15,
    ST_LOADC  = 5'd16,
    ST_WAITC  = 5'd17,
    ST_EIDLE  = 5'd18
  } state_t;

  // States whose ALU result can overflow and abort the chain.
  function automatic logic is_arith(state_t s);
    return (s inside {ST_MUL1, ST_ADD1, ST_MUL2, ST_SUB2,
                      ST_MUL3, ST_ADD3, ST_MUL4, ST_SUB4});
  endfunction

endpackage

// File: rtl/fir_sequencer.sv
// Moore control unit sequencing the FIR datapath:
// coefficient loads, sample shift and the signed MAC chain.
module fir_sequencer
  import fir_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       dr,
  input  logic       lc,
  input  logic       overflow,
  output logic [2:0] op,
  output logic [3:0] src1,
  output logic [3:0] src2,
  output logic [3:0] dest,
  output logic       cnt_up,
  output logic       clear,
  output logic       modwait,
  output logic       err
);

  state_t     state;
  state_t     state_nx;
  logic [1:0] cidx;
  op_t        op_d;

  // State and coefficient index registers; cidx advances only on a load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cidx  <= 2'd0;
    end else begin
      state <= state_nx;
      if (state == ST_LOADC)
        cidx <= cidx + 2'd1;
    end
  end

  // Next-state selection; an ALU overflow diverts the chain to EIDLE.
  always_comb begin
    state_nx = state;
    if (is_arith(state) && overflow) begin
      state_nx = ST_EIDLE;
    end else begin
      unique case (state)
        ST_IDLE, ST_EIDLE: begin
          if (dr)
            state_nx = ST_STORE;
          else if (lc)
            state_nx = ST_LOADC;
        end
        ST_STORE:  state_nx = dr ? ST_SHIFT4 : ST_EIDLE;
        ST_SHIFT4: state_nx = ST_SHIFT3;
        ST_SHIFT3: state_nx = ST_SHIFT2;
        ST_SHIFT2: state_nx = ST_SHIFT1;
        ST_SHIFT1: state_nx = ST_ZERO;
        ST_ZERO:   state_nx = ST_MUL1;
        ST_MUL1:   state_nx = ST_ADD1;
        ST_ADD1:   state_nx = ST_MUL2;
        ST_MUL2:   state_nx = ST_SUB2;
        ST_SUB2:   state_nx = ST_MUL3;
        ST_MUL3:   state_nx = ST_ADD3;
        ST_ADD3:   state_nx = ST_MUL4;
        ST_MUL4:   state_nx = ST_SUB4;
        ST_SUB4:   state_nx = ST_DONE;
        ST_DONE:   state_nx = ST_IDLE;
        ST_LOADC:  state_nx = ST_WAITC;
        ST_WAITC: begin
          if (!lc)
            state_nx = ST_IDLE;
        end
        default:   state_nx = ST_IDLE;
      endcase
    end
  end

  // Output decode from the state (and cidx for coefficient loads).
  always_comb begin
    op_d    = OP_NOP;
    src1    = REG_ACC;
    src2    = REG_ACC;
    dest    = REG_ACC;
    cnt_up  = 1'b0;
    clear   = 1'b0;
    modwait = 1'b0;
    err     = 1'b0;
    unique case (state)
      ST_IDLE, ST_WAITC: ;
      ST_EIDLE: err = 1'b1;
      ST_STORE: begin
        op_d    = OP_LOAD1;
        dest    = REG_STAGE;
        modwait = 1'b1;
      end
      ST_SHIFT4: begin
        op_d    = OP_COPY;
        src1    = REG_S3;
        dest    = REG_S4;
        modwait = 1'b1;
      end
      ST_SHIFT3: begin
        op_d    = OP_COPY;
        src1    = REG_S2;
        dest    = REG_S3;
        modwait = 1'b1;
      end
      ST_SHIFT2: begin
        op_d    = OP_COPY;
        src1    = REG_S1;
        dest    = REG_S2;
        modwait = 1'b1;
      end
      ST_SHIFT1: begin
        op_d    = OP_COPY;
        src1    = REG_STAGE;
        dest    = REG_S1;
        modwait = 1'b1;
      end
      ST_ZERO: begin
        op_d    = OP_SUB;
        modwait = 1'b1;
      end
      ST_MUL1: begin
        op_d    = OP_MUL;
        src1    = REG_S1;
        src2    = REG_F0;
        dest    = REG_TMP;
        modwait = 1'b1;
      end
      ST_MUL2: begin
        op_d    = OP_MUL;
        src1    = REG_S2;
        src2    = REG_F1;
        dest    = REG_TMP;
        modwait = 1'b1;
      end
      ST_MUL3: begin
        op_d    = OP_MUL;
        src1    = REG_S3;
        src2    = REG_F2;
        dest    = REG_TMP;
        modwait = 1'b1;
      end
      ST_MUL4: begin
        op_d    = OP_MUL;
        src1    = REG_S4;
        src2    = REG_F3;
        dest    = REG_TMP;
        modwait = 1'b1;
      end
      ST_ADD1, ST_ADD3: begin
        op_d    = OP_ADD;
        src2    = REG_TMP;
        modwait = 1'b1;
      end
      ST_SUB2, ST_SUB4: begin
        op_d    = OP_SUB;
        src2    = REG_TMP;
        modwait = 1'b1;
      end
      ST_DONE: begin
        cnt_up  = 1'b1;
        modwait = 1'b1;
      end
      ST_LOADC: begin
        op_d    = OP_LOAD2;
        dest    = REG_F0 + {2'b00, cidx};
        clear   = (cidx == 2'd0);
        modwait = 1'b1;
      end
      default: ;
    endcase
  end

  assign op = op_d;

endmodule
